acc_drain: RTL and testbench
============================

Name: acc_drain

Overview:
- Reader end of the accumulator interface.
- Waits for the accumulator's full flag, then snapshots all accumulated entries in one cycle.
- Streams the entries one per handshake (valid/ready) toward unified-buffer writeback, each tagged with a sequential address.
- When the last entry is accepted, pulses a clear request so the accumulator can refill for the next tile.

Parameters:
- NUM_ENTRIES, 2, number of accumulator entries drained per tile.
- DATA_WIDTH, 32, width of each accumulated value.
- ADDR_WIDTH, 8, width of the writeback address.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- acc_full  input  1  accumulator full flag; level, held high until the accumulator is cleared.
- acc_data  input  NUM_ENTRIES*DATA_WIDTH  flattened accumulator contents; entry i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- base_addr  input  ADDR_WIDTH  writeback start address; sampled together with the snapshot.
- out_valid  output  1  out_data/out_addr hold a valid entry.
- out_ready  input  1  consumer accepts the entry this cycle.
- out_data  output  DATA_WIDTH  current entry value.
- out_addr  output  ADDR_WIDTH  current entry address.
- busy  output  1  a drain is in progress.
- done  output  1  one-cycle pulse after the last entry is accepted.
- acc_clear  output  1  one-cycle pulse, coincident with done; the accumulator's reset/clear request.

Behaviour:
- Reset (async assert, any state):
  - out_valid=0, out_data=0, out_addr=0, busy=0, done=0, acc_clear=0.
  - FSM goes to IDLE, index=0, armed=1, snapshot registers cleared to 0.
  - Reset mid-drain abandons the drain; no done or acc_clear is generated.
- FSM states:
  - IDLE -> SEND when acc_full=1 and armed=1, sampled at a rising edge.
    - On that edge: latch all NUM_ENTRIES values of acc_data into snapshot registers, latch base_addr, set index=0, busy=1, armed=0.
  - SEND: out_valid=1, out_data=snapshot[index], out_addr=base_latched+index.
    - Address is computed modulo 2^ADDR_WIDTH; wrap past all-ones to 0 is legal and silent.
    - Handshake fires when out_valid && out_ready.
    - On a handshake with index<NUM_ENTRIES-1: index increments and the next entry appears the following cycle. There is no bubble between back-to-back accepted entries.
    - On a handshake with index=NUM_ENTRIES-1: go to DONE and drop out_valid.
    - While out_valid=1 and out_ready=0: out_data and out_addr hold stable; out_valid stays high.
  - DONE (one cycle): done=1, acc_clear=1, busy=0 (busy=1 only while in SEND). Next state is IDLE.
- Latency and sampling:
  - First out_valid appears one cycle after acc_full is sampled high in IDLE.
  - With out_ready held high, a drain takes NUM_ENTRIES cycles of out_valid plus 1 DONE cycle.
  - acc_data is sampled only at the snapshot edge. Later changes to acc_data have no effect on the current drain.
- Re-arm rule:
  - armed returns to 1 only when acc_full is sampled low while in IDLE.
  - A stale acc_full that is still high after DONE (accumulator slow to clear) does not trigger a second drain.
- Data values:
  - Zero-valued entries are transmitted like any other value; no filtering.
  - Data passes through unmodified at DATA_WIDTH; no arithmetic on data.
- Simultaneous events:
  - acc_full rising in SEND or DONE is ignored. It is honoured only once IDLE has re-armed.
  - out_ready high while out_valid=0 has no effect.

Decomposition:
- Shared package holds:
  - FSM state typedef (IDLE, SEND, DONE), 2-bit encoding.
  - Default DATA_WIDTH and ADDR_WIDTH constants, shared with the accumulator and unified buffer.
- No sub-module is required. An optional skid-free output register stage is kept inline.
- The index counter width is derived from NUM_ENTRIES via $clog2, minimum 1.

Test Plan:
- Basic drain: acc_data={32'd20,32'd7}, base_addr=8'h10, acc_full=1, out_ready=1 -> out_valid for 2 cycles with (7,0x10) then (20,0x11); then done=acc_clear=1 for exactly 1 cycle; busy high for exactly the 2 SEND cycles.
- Backpressure: same stimulus, out_ready low for 3 cycles on entry 0 -> out_data=7 and out_addr=0x10 held stable with out_valid=1 for all 3 cycles; entry 1 follows the cycle after acceptance.
- Address wrap: base_addr=8'hFF -> addresses 0xFF then 0x00.
- Stale full: acc_full kept high for 5 cycles after done -> no second drain; drop acc_full for 1 cycle, raise it again with new data {5,9} -> a second drain sends 9 then 5.
- Snapshot isolation: change acc_data to {1,1} one cycle after the drain starts -> original values 7 and 20 are still sent.
- Reset mid-drain: assert reset while entry 0 is stalled -> all outputs 0 immediately, no done/acc_clear; after release, acc_full still high -> a new drain starts from index 0.

Source files
------------

// File: rtl/acc_drain_pkg.sv
// Shared definitions for the accumulator drain path.
// Holds the drain FSM state type and the default data/address widths
// shared with the accumulator and the unified buffer, plus a helper
// that sizes the entry index counter.
package acc_drain_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index counter width: ceil(log2(n)), never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_drain_if.sv
// Writeback stream interface from the accumulator drain to the unified
// buffer.
//   out_valid : entry on out_data/out_addr is valid (master -> slave)
//   out_ready : consumer accepts the entry this cycle (slave -> master)
//   out_data  : entry value                           (master -> slave)
//   out_addr  : writeback address of the entry        (master -> slave)
interface acc_drain_if
  import acc_drain_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_addr;

  modport master (
    output out_valid,
    output out_data,
    output out_addr,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_addr,
    output out_ready
  );

endinterface

// File: rtl/acc_drain.sv
// Accumulator drain: reader end of the accumulator interface.
// Waits for acc_full, snapshots every accumulated entry in one cycle,
// streams the entries one per valid/ready handshake with sequential
// writeback addresses, then pulses done/acc_clear so the accumulator
// can refill for the next tile.
// Ports:
//   clk       : system clock, rising edge
//   reset     : asynchronous active-high reset
//   acc_full  : accumulator full flag (level)
//   acc_data  : flattened entries, entry i at [i*DATA_WIDTH +: DATA_WIDTH]
//   base_addr : writeback start address, captured with the snapshot
//   out_if    : writeback stream (master side: valid/data/addr, ready in)
//   busy      : high while entries are being streamed
//   done      : one-cycle pulse after the last entry is accepted
//   acc_clear : one-cycle clear request to the accumulator, with done
module acc_drain
  import acc_drain_pkg::*;
#(
  parameter int NUM_ENTRIES = 2,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              acc_full,
  input  logic [NUM_ENTRIES*DATA_WIDTH-1:0] acc_data,
  input  logic [ADDR_WIDTH-1:0]             base_addr,
  acc_drain_if.master                       out_if,
  output logic                              busy,
  output logic                              done,
  output logic                              acc_clear
);

  localparam int IDX_W = idx_width(NUM_ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  state_t                 state;
  logic [IDX_W-1:0]       index;
  logic [IDX_W-1:0]       next_idx;
  logic                   armed;
  logic [ADDR_WIDTH-1:0]  base_lat;
  logic [DATA_WIDTH-1:0]  snap [NUM_ENTRIES];
  logic                   hs;

  assign next_idx = index + IDX_W'(1);
  assign hs       = out_if.out_valid && out_if.out_ready;

  // All outputs are registered. The output stage is loaded with the next
  // entry on the same edge that accepts the current one, so back-to-back
  // accepted entries stream without a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      index            <= '0;
      armed            <= 1'b1;
      base_lat         <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) snap[i] <= '0;
      out_if.out_valid <= 1'b0;
      out_if.out_data  <= '0;
      out_if.out_addr  <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      acc_clear        <= 1'b0;
    end else begin
      done      <= 1'b0;
      acc_clear <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (acc_full && armed) begin
            for (int i = 0; i < NUM_ENTRIES; i++)
              snap[i] <= acc_data[i*DATA_WIDTH +: DATA_WIDTH];
            base_lat         <= base_addr;
            index            <= '0;
            armed            <= 1'b0;
            busy             <= 1'b1;
            out_if.out_valid <= 1'b1;
            out_if.out_data  <= acc_data[DATA_WIDTH-1:0];
            out_if.out_addr  <= base_addr;
            state            <= ST_SEND;
          end else if (!acc_full) begin
            // Only a low full flag seen in IDLE re-arms; a flag still high
            // from the previous tile must not start a second drain.
            armed <= 1'b1;
          end
        end
        ST_SEND: begin
          if (hs) begin
            if (index == LAST_IDX) begin
              out_if.out_valid <= 1'b0;
              busy             <= 1'b0;
              done             <= 1'b1;
              acc_clear        <= 1'b1;
              state            <= ST_DONE;
            end else begin
              index           <= next_idx;
              out_if.out_data <= snap[next_idx];
              // Address arithmetic wraps modulo 2^ADDR_WIDTH.
              out_if.out_addr <= base_lat + ADDR_WIDTH'(next_idx);
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_drain.sv
module tb_acc_drain;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            acc_full;
  logic [N*DW-1:0] acc_data;
  logic [AW-1:0]   base_addr;
  logic            busy;
  logic            done;
  logic            acc_clear;

  int n_assert = 0;
  int n_fail   = 0;

  acc_drain_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  acc_drain #(
    .NUM_ENTRIES(N),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .acc_full (acc_full),
    .acc_data (acc_data),
    .base_addr(base_addr),
    .out_if   (bus.master),
    .busy     (busy),
    .done     (done),
    .acc_clear(acc_clear)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, ".busy"},  64'(busy),          64'd0);
    chk({tag, ".done"},  64'(done),          64'd0);
    chk({tag, ".clear"}, 64'(acc_clear),     64'd0);
  endtask

  // Reference: entries are sent in index order, entry i at (base+i) mod 2^AW,
  // using the values present at the snapshot edge. Each entry stays on the
  // bus for its stall cycles and then one accepting cycle.
  task automatic drain(input string tag, input logic [N*DW-1:0] d,
                       input logic [AW-1:0] base, input int stall0,
                       input bit rnd_stall, input bit corrupt);
    logic [DW-1:0] exp_d [N];
    logic [AW-1:0] exp_a [N];
    int ns;
    for (int i = 0; i < N; i++) begin
      exp_d[i] = d[i*DW +: DW];
      exp_a[i] = AW'(int'(base) + i);
    end
    acc_full = 1'b0;
    bus.out_ready = 1'b0;
    step();
    chk_idle({tag, ".pre"});
    acc_data  = d;
    base_addr = base;
    acc_full  = 1'b1;
    step();
    if (corrupt) acc_data = {32'd1, 32'd1};
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s.e%0d.valid", tag, i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("%s.e%0d.busy", tag, i),  64'(busy),          64'd1);
      chk($sformatf("%s.e%0d.data", tag, i),  64'(bus.out_data),  64'(exp_d[i]));
      chk($sformatf("%s.e%0d.addr", tag, i),  64'(bus.out_addr),  64'(exp_a[i]));
      chk($sformatf("%s.e%0d.done", tag, i),  64'(done),          64'd0);
      ns = (i == 0) ? stall0 : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s < ns; s++) begin
        bus.out_ready = 1'b0;
        step();
        chk($sformatf("%s.e%0d.hold%0d.valid", tag, i, s), 64'(bus.out_valid), 64'd1);
        chk($sformatf("%s.e%0d.hold%0d.data", tag, i, s),  64'(bus.out_data),  64'(exp_d[i]));
        chk($sformatf("%s.e%0d.hold%0d.addr", tag, i, s),  64'(bus.out_addr),  64'(exp_a[i]));
      end
      bus.out_ready = 1'b1;
      step();
    end
    chk({tag, ".fin.valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, ".fin.done"},  64'(done),          64'd1);
    chk({tag, ".fin.clear"}, 64'(acc_clear),     64'd1);
    chk({tag, ".fin.busy"},  64'(busy),          64'd0);
    bus.out_ready = 1'b0;
    step();
    chk_idle({tag, ".post"});
  endtask

  initial begin
    logic [N*DW-1:0] rd;
    reset         = 1'b1;
    acc_full      = 1'b0;
    acc_data      = '0;
    base_addr     = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    chk_idle("reset");
    chk("reset.data", 64'(bus.out_data), 64'd0);
    chk("reset.addr", 64'(bus.out_addr), 64'd0);
    reset = 1'b0;
    step();

    drain("basic", {32'd20, 32'd7}, 8'h10, 0, 1'b0, 1'b0);
    drain("backp", {32'd20, 32'd7}, 8'h10, 3, 1'b0, 1'b0);
    drain("wrap",  {32'd20, 32'd7}, 8'hFF, 0, 1'b0, 1'b0);

    // acc_full left high after the drain: no second drain, ready ignored.
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_idle($sformatf("stale%0d", k));
    end
    drain("refill", {32'd5, 32'd9}, 8'h20, 0, 1'b0, 1'b0);
    drain("isol",   {32'd20, 32'd7}, 8'h10, 1, 1'b0, 1'b1);
    drain("zeros",  {32'd0, 32'd0}, 8'h40, 0, 1'b0, 1'b0);

    // Reset while entry 0 is stalled.
    acc_full = 1'b0;
    step();
    acc_data  = {32'hCAFE0002, 32'hCAFE0001};
    base_addr = 8'h80;
    acc_full  = 1'b1;
    bus.out_ready = 1'b0;
    step();
    chk("rst.start.valid", 64'(bus.out_valid), 64'd1);
    step();
    reset = 1'b1;
    #1;
    chk_idle("rst.async");
    chk("rst.async.data", 64'(bus.out_data), 64'd0);
    chk("rst.async.addr", 64'(bus.out_addr), 64'd0);
    step();
    chk_idle("rst.hold");
    reset = 1'b0;
    step();
    chk("rst.new.valid", 64'(bus.out_valid), 64'd1);
    chk("rst.new.data",  64'(bus.out_data),  64'hCAFE0001);
    chk("rst.new.addr",  64'(bus.out_addr),  64'h80);
    bus.out_ready = 1'b1;
    step();
    chk("rst.new.e1.data", 64'(bus.out_data), 64'hCAFE0002);
    chk("rst.new.e1.addr", 64'(bus.out_addr), 64'h81);
    step();
    chk("rst.new.done",  64'(done),      64'd1);
    chk("rst.new.clear", 64'(acc_clear), 64'd1);
    bus.out_ready = 1'b0;
    step();

    for (int t = 0; t < 20; t++) begin
      rd = {$urandom, $urandom};
      drain($sformatf("rnd%0d", t), rd, AW'($urandom), int'($urandom_range(0, 3)),
            1'b1, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
